kb_uart_bridge: RTL and testbench

Parametrised PS/2 keyboard-to-UART bridge that replaces the fixed keyboard test path. Consumes the scan-code byte stream from the PS/2 receiver, tracks make/break, extended-prefix, Shift and Caps Lock state, and converts keys to shifted ASCII or to a hex dump of raw scan codes. Results pass through a parametrised FIFO and drain into the UART transmitter's write port under `tx_full` back-pressure.

---
 rtl/kb_bridge_pkg.sv | 24 ++
 rtl/kb_ascii_lut.sv | 60 ++++++
 rtl/kb_uart_bridge.sv | 158 +++++++++++++++
 tb/tb_kb_uart_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_bridge_pkg.sv
// Shared constants, decoder state type and hex helper for the PS/2 keyboard
// to UART bridge.
package kb_bridge_pkg;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_e;

  // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/kb_ascii_lut.sv
// Scan-code set 2 to ASCII translation (US layout). Returns 0x00 for codes
// with no printable meaning; is_letter depends on scan_code only.
module kb_ascii_lut
  import kb_bridge_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       is_letter
);

  logic [7:0] lower_c;
  logic [7:0] upper_c;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a latch behind.
  always_comb begin
    lower_c = 8'h00;
    upper_c = 8'h00;
    case (scan_code)
      8'h1C: lower_c = "a";  8'h32: lower_c = "b";  8'h21: lower_c = "c";  8'h23: lower_c = "d";
      8'h24: lower_c = "e";  8'h2B: lower_c = "f";  8'h34: lower_c = "g";  8'h33: lower_c = "h";
      8'h43: lower_c = "i";  8'h3B: lower_c = "j";  8'h42: lower_c = "k";  8'h4B: lower_c = "l";
      8'h3A: lower_c = "m";  8'h31: lower_c = "n";  8'h44: lower_c = "o";  8'h4D: lower_c = "p";
      8'h15: lower_c = "q";  8'h2D: lower_c = "r";  8'h1B: lower_c = "s";  8'h2C: lower_c = "t";
      8'h3C: lower_c = "u";  8'h2A: lower_c = "v";  8'h1D: lower_c = "w";  8'h22: lower_c = "x";
      8'h35: lower_c = "y";  8'h1A: lower_c = "z";
      8'h45: begin lower_c = "0"; upper_c = ")"; end
      8'h16: begin lower_c = "1"; upper_c = "!"; end
      8'h1E: begin lower_c = "2"; upper_c = "@"; end
      8'h26: begin lower_c = "3"; upper_c = "#"; end
      8'h25: begin lower_c = "4"; upper_c = "$"; end
      8'h2E: begin lower_c = "5"; upper_c = "%"; end
      8'h36: begin lower_c = "6"; upper_c = "^"; end
      8'h3D: begin lower_c = "7"; upper_c = "&"; end
      8'h3E: begin lower_c = "8"; upper_c = "*"; end
      8'h46: begin lower_c = "9"; upper_c = "("; end
      8'h0E: begin lower_c = 8'h60; upper_c = "~"; end
      8'h4E: begin lower_c = "-"; upper_c = "_"; end
      8'h55: begin lower_c = "="; upper_c = "+"; end
      8'h54: begin lower_c = "["; upper_c = "{"; end
      8'h5B: begin lower_c = "]"; upper_c = "}"; end
      8'h5D: begin lower_c = "\\"; upper_c = "|"; end
      8'h4C: begin lower_c = ";"; upper_c = ":"; end
      8'h52: begin lower_c = "'"; upper_c = "\""; end
      8'h41: begin lower_c = ","; upper_c = "<"; end
      8'h49: begin lower_c = "."; upper_c = ">"; end
      8'h4A: begin lower_c = "/"; upper_c = "?"; end
      8'h5A: begin lower_c = 8'h0D; upper_c = 8'h0D; end
      8'h66: begin lower_c = 8'h08; upper_c = 8'h08; end
      8'h29: begin lower_c = ASCII_SPACE; upper_c = ASCII_SPACE; end
      8'h0D: begin lower_c = 8'h09; upper_c = 8'h09; end
      default: ;
    endcase
    is_letter = (lower_c >= "a") && (lower_c <= "z");
    if (is_letter) upper_c = lower_c - 8'h20;
    ascii = upper ? upper_c : lower_c;
  end

endmodule

// File: rtl/kb_uart_bridge.sv
// PS/2 scan-code stream to UART bridge: make/break decoding, modifier
// tracking, ASCII or hex-dump conversion, and a character FIFO to the TX port.
module kb_uart_bridge
  import kb_bridge_pkg::*;
#(
  parameter int FIFO_AW  = 4,
  parameter bit HEX_MODE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         scan_code,
  input  logic               scan_valid,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [7:0]         w_data,
  output logic               shift_held,
  output logic               caps_lock,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  dec_state_e       state, state_nxt;
  logic             lshift, rshift;
  logic             lshift_nxt, rshift_nxt, caps_nxt;
  logic             key_make, key_break, is_modifier;
  logic             accept, drop_busy;
  logic [1:0]       emit_cnt;
  logic [7:0]       emit_byte;
  logic             push, push_ok, pop;
  logic [7:0]       push_data;
  logic [7:0]       lut_ascii;
  logic             lut_letter, upper;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;

  // In hex mode the emitter owns the FIFO write port for two more cycles.
  assign accept     = scan_valid && (emit_cnt == 2'd0);
  assign drop_busy  = scan_valid && (emit_cnt != 2'd0);
  assign shift_held = lshift | rshift;
  assign upper      = shift_held ^ (caps_lock & lut_letter);
  assign is_modifier = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) ||
                       (scan_code == SC_CAPS);

  kb_ascii_lut u_lut (
    .scan_code (scan_code),
    .upper     (upper),
    .ascii     (lut_ascii),
    .is_letter (lut_letter)
  );

  always_comb begin
    state_nxt = state;
    key_make  = 1'b0;
    key_break = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)    state_nxt = ST_BRK;
          else if (scan_code == SC_EXT) state_nxt = ST_EXT;
          else                          key_make  = 1'b1;
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          key_break = 1'b1;
        end
        ST_EXT:     state_nxt = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    caps_nxt   = caps_lock;
    if (key_make) begin
      case (scan_code)
        SC_LSHIFT: lshift_nxt = 1'b1;
        SC_RSHIFT: rshift_nxt = 1'b1;
        SC_CAPS:   caps_nxt   = ~caps_lock;
        default: ;
      endcase
    end
    if (key_break) begin
      if (scan_code == SC_LSHIFT) lshift_nxt = 1'b0;
      if (scan_code == SC_RSHIFT) rshift_nxt = 1'b0;
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    if (HEX_MODE) begin
      if (accept) begin
        push      = 1'b1;
        push_data = hex_char(scan_code[7:4]);
      end else if (emit_cnt == 2'd2) begin
        push      = 1'b1;
        push_data = hex_char(emit_byte[3:0]);
      end else if (emit_cnt == 2'd1) begin
        push      = 1'b1;
        push_data = ASCII_SPACE;
      end
    end else if (key_make && !is_modifier && (lut_ascii != 8'h00)) begin
      push      = 1'b1;
      push_data = lut_ascii;
    end
  end

  // Extra pointer bit separates full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;
  assign pop        = !fifo_empty && !tx_full;
  assign push_ok    = push && (!fifo_full || pop);
  assign wr_uart    = pop;
  assign w_data     = fifo_empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_lock <= 1'b0;
      overflow  <= 1'b0;
      emit_cnt  <= 2'd0;
      emit_byte <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      caps_lock <= caps_nxt;
      if ((push && !push_ok) || drop_busy) overflow <= 1'b1;
      if (HEX_MODE && accept) begin
        emit_byte <= scan_code;
        emit_cnt  <= 2'd2;
      end else if (emit_cnt != 2'd0) begin
        emit_cnt  <= emit_cnt - 2'd1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers empties the
  // FIFO and w_data is forced to zero while empty, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_kb_uart_bridge.sv
// Bench for kb_uart_bridge: an ASCII instance with a 4-deep FIFO and a hex
// instance, checked against a key-event reference model.
module tb_kb_uart_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] code_a, code_h;
  logic       valid_a, valid_h, txf_a, txf_h;
  logic       wr_a, wr_h, sh_a, sh_h, cl_a, cl_h, ov_a, ov_h;
  logic [7:0] wd_a, wd_h;
  logic [2:0] lvl_a;
  logic [4:0] lvl_h;

  kb_uart_bridge #(.FIFO_AW(2), .HEX_MODE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .scan_code(code_a), .scan_valid(valid_a),
    .tx_full(txf_a), .wr_uart(wr_a), .w_data(wd_a), .shift_held(sh_a),
    .caps_lock(cl_a), .overflow(ov_a), .fifo_level(lvl_a)
  );

  kb_uart_bridge #(.FIFO_AW(4), .HEX_MODE(1'b1)) dut_h (
    .clk(clk), .reset(reset), .scan_code(code_h), .scan_valid(valid_h),
    .tx_full(txf_h), .wr_uart(wr_h), .w_data(wd_h), .shift_held(sh_h),
    .caps_lock(cl_h), .overflow(ov_h), .fifo_level(lvl_h)
  );

  // US layout reference data: letters a..z, digits 0..9 and shifted digits.
  localparam logic [7:0] LETTER_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
    8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] DIGIT_SHIFT [10] = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};
  localparam logic [7:0] POOL [22] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h1A,
    8'h22, 8'h45, 8'h16, 8'h1E, 8'h46, 8'h5A, 8'h66, 8'h29, 8'h12, 8'h59, 8'h58,
    8'hF0, 8'hE0, 8'h05, 8'h76};

  typedef struct {
    bit pre_e0;
    bit pre_f0;
    bit ls;
    bit rs;
    bit caps;
  } kbd_t;

  kbd_t       ka, kh;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] got_a[$], got_h[$], exp_a[$], exp_h[$];

  always @(negedge clk) begin
    if (wr_a) got_a.push_back(wd_a);
    if (wr_h) got_h.push_back(wd_h);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A byte is a prefix (E0 only first, F0 once); anything else ends a key event.
  task automatic kbd_step(inout kbd_t k, input logic [7:0] b, output bit is_key);
    is_key = 1'b0;
    if ((b == 8'hE0 && !k.pre_e0 && !k.pre_f0) || (b == 8'hF0 && !k.pre_f0)) begin
      if (b == 8'hE0) k.pre_e0 = 1'b1;
      else            k.pre_f0 = 1'b1;
    end else begin
      if (!k.pre_e0 && !k.pre_f0) begin
        if (b == 8'h12)      k.ls = 1'b1;
        else if (b == 8'h59) k.rs = 1'b1;
        else if (b == 8'h58) k.caps = !k.caps;
        else                 is_key = 1'b1;
      end else if (!k.pre_e0) begin
        if (b == 8'h12) k.ls = 1'b0;
        if (b == 8'h59) k.rs = 1'b0;
      end
      k.pre_e0 = 1'b0;
      k.pre_f0 = 1'b0;
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [7:0] b, input bit shift, input bit caps);
    for (int i = 0; i < 26; i++)
      if (b == LETTER_SC[i]) return (shift ^ caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (b == DIGIT_SC[i]) return shift ? DIGIT_SHIFT[i] : 8'(8'h30 + i);
    case (b)
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      8'h29:   return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hex_of(input logic [3:0] n);
    return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
  endfunction

  task automatic model_a(input logic [7:0] b);
    bit         key;
    logic [7:0] c;
    kbd_step(ka, b, key);
    if (key) begin
      c = ascii_of(b, ka.ls | ka.rs, ka.caps);
      if (c != 8'h00) exp_a.push_back(c);
    end
  endtask

  task automatic model_h(input logic [7:0] b);
    bit key;
    kbd_step(kh, b, key);
    exp_h.push_back(hex_of(b[7:4]));
    exp_h.push_back(hex_of(b[3:0]));
    exp_h.push_back(8'h20);
  endtask

  task automatic send_a(input logic [7:0] b);
    code_a = b;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    model_a(b);
    check($sformatf("a_shift after %h", b), sh_a, ka.ls | ka.rs);
    check($sformatf("a_caps after %h", b), cl_a, ka.caps);
  endtask

  task automatic send_h(input logic [7:0] b);
    code_h = b;
    valid_h = 1'b1;
    step();
    valid_h = 1'b0;
    model_h(b);
    check($sformatf("h_shift after %h", b), sh_h, kh.ls | kh.rs);
    step();
    step();
  endtask

  task automatic cmp_a(input string tag);
    for (int i = 0; i < 100 && lvl_a != 0; i++) step();
    check({tag, " drained level"}, lvl_a, 0);
    check({tag, " char count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check($sformatf("%s char %0d", tag, i), got_a[i], exp_a[i]);
    got_a.delete();
    exp_a.delete();
  endtask

  task automatic cmp_h(input string tag);
    for (int i = 0; i < 100 && lvl_h != 0; i++) step();
    check({tag, " drained level"}, lvl_h, 0);
    check({tag, " char count"}, got_h.size(), exp_h.size());
    for (int i = 0; i < exp_h.size() && i < got_h.size(); i++)
      check($sformatf("%s char %0d", tag, i), got_h[i], exp_h[i]);
    got_h.delete();
    exp_h.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    ka = '{default: 1'b0};
    kh = '{default: 1'b0};
    got_a.delete(); exp_a.delete();
    got_h.delete(); exp_h.delete();
  endtask

  initial begin
    reset = 1'b0;
    code_a = 8'h00; code_h = 8'h00;
    valid_a = 1'b0; valid_h = 1'b0;
    txf_a = 1'b0; txf_h = 1'b0;
    ka = '{default: 1'b0};
    kh = '{default: 1'b0};
    #12;
    check("rst wr_uart", wr_a, 0);
    check("rst w_data", wd_a, 0);
    check("rst shift", sh_a, 0);
    check("rst caps", cl_a, 0);
    check("rst overflow", ov_a, 0);
    check("rst level", lvl_a, 0);
    check("rst hex level", lvl_h, 0);
    step();
    reset = 1'b1;
    step();

    // First-byte latency: write at the next edge, wr_uart in the next cycle.
    code_a = 8'h1C;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    model_a(8'h1C);
    check("lat wr_uart", wr_a, 1);
    check("lat w_data", wd_a, 8'h61);
    check("lat level", lvl_a, 1);
    send_a(8'hF0); send_a(8'h1C);
    cmp_a("make_break");

    send_a(8'h12); send_a(8'h1C); send_a(8'hF0); send_a(8'h1C);
    send_a(8'hF0); send_a(8'h12); send_a(8'h16);
    cmp_a("shift");

    send_a(8'h58); send_a(8'h1C); send_a(8'h16); send_a(8'h12); send_a(8'h1C);
    cmp_a("caps");

    send_a(8'hE0); send_a(8'h75); send_a(8'hE0); send_a(8'hF0); send_a(8'h75);
    send_a(8'h1C);
    cmp_a("extended");

    for (int n = 0; n < 200; n++) begin
      send_a(POOL[$urandom_range(0, 21)]);
      repeat ($urandom_range(0, 2)) step();
    end
    cmp_a("ascii_rand");
    check("ascii_rand overflow", ov_a, 0);

    pulse_reset();
    check("rst2 caps", cl_a, 0);
    txf_a = 1'b1;
    send_a(8'h1C); send_a(8'h32); send_a(8'h21); send_a(8'h23); send_a(8'h24);
    exp_a.pop_back();  // fifth char finds the 4-deep FIFO full and is dropped
    check("full level", lvl_a, 4);
    check("full overflow", ov_a, 1);
    repeat (5) step();
    check("stall level", lvl_a, 4);
    check("stall no write", got_a.size(), 0);
    txf_a = 1'b0;
    cmp_a("full_drain");

    // Hex mode: three consecutive FIFO writes per byte.
    txf_h = 1'b1;
    code_h = 8'hF0;
    valid_h = 1'b1;
    step();
    valid_h = 1'b0;
    check("hex level 1", lvl_h, 1);
    step();
    check("hex level 2", lvl_h, 2);
    step();
    check("hex level 3", lvl_h, 3);
    model_h(8'hF0);
    txf_h = 1'b0;
    cmp_h("hex_f0");

    send_h(8'h1C); send_h(8'h12);
    cmp_h("hex_shift");

    for (int n = 0; n < 40; n++) send_h(8'($urandom_range(0, 255)));
    cmp_h("hex_rand");
    check("hex_rand overflow", ov_h, 0);

    code_h = 8'h3C;
    valid_h = 1'b1;
    step();
    code_h = 8'h4D;
    step();
    valid_h = 1'b0;
    model_h(8'h3C);
    step();
    step();
    check("hex busy overflow", ov_h, 1);
    cmp_h("hex_busy");

    send_h(8'h1C); send_h(8'h12);
    check("pre-reset shift", sh_h, 1);
    cmp_h("hex_pre_reset");

    // Reset in the middle of a hex emission.
    txf_h = 1'b1;
    code_h = 8'hAB;
    valid_h = 1'b1;
    step();
    valid_h = 1'b0;
    reset = 1'b0;
    #1;
    check("mid rst wr_uart", wr_h, 0);
    check("mid rst w_data", wd_h, 0);
    check("mid rst shift", sh_h, 0);
    check("mid rst caps", cl_h, 0);
    check("mid rst overflow", ov_h, 0);
    check("mid rst level", lvl_h, 0);
    check("mid rst ascii overflow", ov_a, 0);
    step();
    step();
    reset = 1'b1;
    txf_h = 1'b0;
    got_h.delete();
    exp_h.delete();
    kh = '{default: 1'b0};
    repeat (6) step();
    check("post rst level", lvl_h, 0);
    check("post rst no chars", got_h.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
